fir_coeff_ctrl: RTL and testbench
=================================

// Module: fir_coeff_ctrl
// PURPOSE
//  Sequencer/configurator in front of the shared FIR_Filter datapath. Forwards the input sample stream with
//  valid/ready and holds host coefficient writes in a shadow bank. On commit it stalls the stream, swaps the
//  shadow bank into the active bank, then injects TAPS-1 zero samples to clear old history, tagging those outputs.
// PARAMETERS
//  DATA_WIDTH   16                   sample width
//  COEFF_WIDTH  16                   coefficient width
//  TAPS         8                    filter taps (>=2)
//  ADDR_WIDTH   3                    coefficient address width, >= clog2(TAPS)
//  FLUSH_EN     1                    1: zero-flush after swap; 0: return straight to RUN
//  COEFF_INIT   {1,2,3,4,4,3,2,1}    reset value of both banks, flattened TAPS*COEFF_WIDTH, tap0 = LSBs
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    reset, asynchronous, active-high
//  s_valid      in   1                    input sample valid
//  s_ready      out  1                    controller accepts the sample
//  s_data       in   DATA_WIDTH           input sample
//  cfg_we       in   1                    shadow coefficient write strobe
//  cfg_addr     in   ADDR_WIDTH           tap index of the write
//  cfg_wdata    in   COEFF_WIDTH          coefficient value
//  cfg_commit   in   1                    request shadow->active swap (single-cycle pulse)
//  cfg_busy     out  1                    swap/flush in progress or pending
//  fir_valid    out  1                    valid_in to FIR
//  fir_data     out  DATA_WIDTH           data_in to FIR
//  fir_coeffs   out  TAPS*COEFF_WIDTH     active coefficient bank, tap0 = LSBs
//  out_discard  out  1                    aligned with FIR valid_out (1-cycle delay): result is flush garbage
// BEHAVIOUR
//  Reset: state=RUN, both banks=COEFF_INIT, flush_cnt=0, pending=0, out_discard=0, cfg_busy=0.
//  States: RUN, SWAP, FLUSH.
//  RUN:   s_ready=1; fir_valid=s_valid, fir_data=s_data (combinational pass-through, zero latency).
//         cfg_commit or pending -> SWAP next cycle; pending cleared.
//  SWAP:  one cycle; s_ready=0, fir_valid=0; active bank <= shadow bank (pre-write value if cfg_we same cycle).
//         -> FLUSH if FLUSH_EN else RUN.
//  FLUSH: s_ready=0; fir_valid=1, fir_data=0 for exactly TAPS-1 cycles (flush_cnt 0..TAPS-2), then RUN.
//  out_discard <= (state==FLUSH); registered so it aligns with FIR's 1-cycle valid_out.
//  cfg_we: writes shadow[cfg_addr] in any state; cfg_addr >= TAPS ignored; active bank unaffected until SWAP.
//  cfg_commit in SWAP/FLUSH sets pending; multiple commits collapse into one; taken on return to RUN.
//  cfg_commit in RUN while pending already set: single swap.
//  cfg_busy = (state!=RUN) | pending.
//  fir_coeffs changes only on the SWAP->next edge; never while a real sample is in flight to FIR.
//  Reset mid-SWAP/FLUSH: immediate return to reset state; banks revert to COEFF_INIT; pending lost.
//  Samples presented while s_ready=0 are held by the upstream (standard valid/ready; no data loss).
// STRUCTURE
//  Shared package fir_pkg: state encoding (RUN/SWAP/FLUSH), COEFF_INIT default, tap-slice helper macro.
//  One sub-module natural: fir_coeff_bank (shadow+active registers, write port, swap strobe, flattened out).
//  Controller FSM, flush counter, pending flag and discard pipe stay in fir_coeff_ctrl.
// TESTING
//  T1 reset: after rst, fir_coeffs = COEFF_INIT, s_ready=1, cfg_busy=0, out_discard=0.
//  T2 pass-through: s_valid=1,s_data=100 in RUN -> fir_valid=1,fir_data=100 same cycle; FIR outputs not discarded.
//  T3 swap+flush: write taps 0..7 = 8, commit -> 1 SWAP cycle, 7 FLUSH cycles of data 0, out_discard high 7 cycles
//     (1 cycle later), fir_coeffs = all 8 from SWAP+1; stream resumes on cycle 9 after commit.
//  T4 commit during FLUSH: second commit with tap3=5 -> cfg_busy stays 1, second SWAP follows FLUSH immediately.
//  T5 write/swap collision: cfg_we tap0=9 in SWAP cycle -> active tap0 keeps old shadow value; next commit loads 9.
//  T6 async rst asserted mid-FLUSH (cnt=3) -> state RUN, banks=COEFF_INIT, out_discard=0 next edge; FLUSH_EN=0 run skips flush.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient controller: FSM state encoding
// and the default coefficient set loaded into both banks at reset.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SWAP  = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_e;

  // Eight 16-bit taps, tap0 in the LSBs: {t7,...,t0} = {1,2,3,4,4,3,2,1}.
  localparam logic [127:0] COEFF_INIT_DEFAULT = {
    16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd3, 16'd2, 16'd1
  };

endpackage

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient storage. The host writes the shadow bank at any
// time. The active bank, which drives the FIR, is loaded from the shadow bank
// only on a swap strobe.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int                              TAPS        = 8,
  parameter int                              COEFF_WIDTH = 16,
  parameter int                              ADDR_WIDTH  = 3,
  parameter logic [TAPS*COEFF_WIDTH-1:0]     COEFF_INIT  = COEFF_INIT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic [COEFF_WIDTH-1:0]        wdata_i,
  input  logic                          swap_i,
  output logic [TAPS*COEFF_WIDTH-1:0]   coeffs_o
);

  logic [COEFF_WIDTH-1:0] shadow_q [TAPS];
  logic [COEFF_WIDTH-1:0] active_q [TAPS];

  // Shadow bank: host writes to taps that exist; out-of-range addresses are dropped.
  // NOTE: these are real registers with a defined power-on value, so they are
  // reset like any other flop; a large RAM would be left unreset instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) shadow_q[i] <= COEFF_INIT[i*COEFF_WIDTH +: COEFF_WIDTH];
    end else if (we_i && (int'(addr_i) < TAPS)) begin
      shadow_q[addr_i] <= wdata_i;
    end
  end

  // Active bank: copies the shadow bank on swap. A write in the same cycle
  // updates the shadow copy only, so the active bank gets the pre-write value.
  // NOTE: non-blocking assignments make every flop sample its inputs from
  // before the edge. That ordering is what provides the pre-write semantics here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) active_q[i] <= COEFF_INIT[i*COEFF_WIDTH +: COEFF_WIDTH];
    end else if (swap_i) begin
      for (int i = 0; i < TAPS; i++) active_q[i] <= shadow_q[i];
    end
  end

  // Flatten the active bank for the FIR, with tap0 in the LSBs.
  always_comb begin
    for (int i = 0; i < TAPS; i++) coeffs_o[i*COEFF_WIDTH +: COEFF_WIDTH] = active_q[i];
  end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Stream sequencer in front of the FIR datapath. It passes samples straight
// through while running. On a commit it stalls the stream, swaps in the new
// coefficient bank, and then optionally pushes TAPS-1 zeros to purge old
// history. Outputs caused by those zeros are tagged as discard.
module fir_coeff_ctrl
  import fir_pkg::*;
#(
  parameter int                              DATA_WIDTH  = 16,
  parameter int                              COEFF_WIDTH = 16,
  parameter int                              TAPS        = 8,
  parameter int                              ADDR_WIDTH  = 3,
  parameter bit                              FLUSH_EN    = 1'b1,
  parameter logic [TAPS*COEFF_WIDTH-1:0]     COEFF_INIT  = COEFF_INIT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          cfg_we,
  input  logic [ADDR_WIDTH-1:0]         cfg_addr,
  input  logic [COEFF_WIDTH-1:0]        cfg_wdata,
  input  logic                          cfg_commit,
  output logic                          cfg_busy,
  output logic                          fir_valid,
  output logic [DATA_WIDTH-1:0]         fir_data,
  output logic [TAPS*COEFF_WIDTH-1:0]   fir_coeffs,
  output logic                          out_discard
);

  // The counter only has to reach TAPS-2.
  localparam int               CNT_W    = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 2);

  ctrl_state_e      state_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             pending_q;
  logic             discard_q;
  logic             in_run;
  logic             swap;

  assign in_run = (state_q == ST_RUN);
  assign swap   = (state_q == ST_SWAP);

  fir_coeff_bank #(
    .TAPS        (TAPS),
    .COEFF_WIDTH (COEFF_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .COEFF_INIT  (COEFF_INIT)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we_i     (cfg_we),
    .addr_i   (cfg_addr),
    .wdata_i  (cfg_wdata),
    .swap_i   (swap),
    .coeffs_o (fir_coeffs)
  );

  // Controller FSM: run / swap / flush, with a pending-commit flag and the flush counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (cfg_commit || pending_q) begin
            state_q   <= ST_SWAP;
            pending_q <= 1'b0;
          end
        end
        ST_SWAP: begin
          if (cfg_commit) pending_q <= 1'b1;
          flush_cnt_q <= '0;
          state_q     <= FLUSH_EN ? ST_FLUSH : ST_RUN;
        end
        ST_FLUSH: begin
          if (cfg_commit) pending_q <= 1'b1;
          if (flush_cnt_q == CNT_LAST) begin
            state_q <= ST_RUN;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Discard tag, delayed one cycle to line up with the FIR's registered valid_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) discard_q <= 1'b0;
    else     discard_q <= (state_q == ST_FLUSH);
  end

  // Stream mux: zero-latency pass-through while running, zeros while flushing.
  // NOTE: each output gets a default before any condition. That way no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    s_ready   = 1'b0;
    fir_valid = 1'b0;
    fir_data  = '0;
    if (in_run) begin
      s_ready   = 1'b1;
      fir_valid = s_valid;
      fir_data  = s_data;
    end else if (state_q == ST_FLUSH) begin
      fir_valid = 1'b1;
    end
  end

  assign cfg_busy    = !in_run || pending_q;
  assign out_discard = discard_q;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Scoreboard bench for fir_coeff_ctrl. Every FIR-side beat the stimulus causes
// is queued with its expected data, coefficients and discard tag. A negedge
// monitor pops and compares each beat. A second instance is built without
// flush to cover the direct SWAP->RUN path.
module tb_fir_coeff_ctrl;
  import fir_pkg::*;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 8;
  localparam int AW   = 3;
  localparam int BW   = TAPS * CW;
  localparam logic [BW-1:0] INIT = COEFF_INIT_DEFAULT;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          cfg_we, cfg_commit, cfg_busy;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic          fir_valid, out_discard;
  logic [DW-1:0] fir_data;
  logic [BW-1:0] fir_coeffs;

  // Second instance: FLUSH_EN = 0.
  logic          b_we, b_commit, b_s_ready, b_busy, b_fir_valid, b_discard;
  logic [AW-1:0] b_addr;
  logic [CW-1:0] b_wdata;
  logic [DW-1:0] b_fir_data;
  logic [BW-1:0] b_coeffs;

  always #5 clk = ~clk;

  fir_coeff_ctrl #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .TAPS(TAPS), .ADDR_WIDTH(AW),
                   .FLUSH_EN(1'b1), .COEFF_INIT(INIT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .fir_valid(fir_valid), .fir_data(fir_data),
    .fir_coeffs(fir_coeffs), .out_discard(out_discard)
  );

  fir_coeff_ctrl #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .TAPS(TAPS), .ADDR_WIDTH(AW),
                   .FLUSH_EN(1'b0), .COEFF_INIT(INIT)) dut_nf (
    .clk(clk), .rst(rst), .s_valid(1'b0), .s_ready(b_s_ready), .s_data('0),
    .cfg_we(b_we), .cfg_addr(b_addr), .cfg_wdata(b_wdata), .cfg_commit(b_commit),
    .cfg_busy(b_busy), .fir_valid(b_fir_valid), .fir_data(b_fir_data),
    .fir_coeffs(b_coeffs), .out_discard(b_discard)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BW-1:0] coeffs;
    logic          flush;
  } beat_t;

  beat_t         exp_q [$];
  beat_t         mon_beat;
  logic [CW-1:0] shadow_m [TAPS];
  logic [BW-1:0] active_m;
  logic          prev_flush;
  bit            mon_en;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  function automatic logic [BW-1:0] pack_shadow();
    logic [BW-1:0] r;
    for (int i = 0; i < TAPS; i++) r[i*CW +: CW] = shadow_m[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one sample for one cycle. The caller guarantees the DUT is in RUN.
  task automatic send(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    exp_q.push_back('{data: d, coeffs: active_m, flush: 1'b0});
    step();
    s_valid = 1'b0;
  endtask

  task automatic write_shadow(input int a, input logic [CW-1:0] v);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_wdata = v;
    shadow_m[a] = v;
    step();
    cfg_we = 1'b0;
  endtask

  // A swap loads the shadow bank as it is right now; queue the flush beats it will produce.
  task automatic expect_swap_flush();
    active_m = pack_shadow();
    for (int i = 0; i < TAPS - 1; i++) exp_q.push_back('{data: '0, coeffs: active_m, flush: 1'b1});
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!s_ready && n < 30) begin
      step();
      n++;
    end
    check(tag, s_ready, 1'b1);
  endtask

  // Monitor: compare every FIR beat and the discard tag one cycle later.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_flush = 1'b0;
    end else begin
      check("out_discard", out_discard, prev_flush);
      prev_flush = 1'b0;
      if (fir_valid) begin
        if (exp_q.size() == 0) begin
          check("fir_valid_unexpected", fir_valid, 1'b0);
        end else begin
          mon_beat = exp_q.pop_front();
          check("fir_data", fir_data, mon_beat.data);
          check("fir_coeffs", fir_coeffs, mon_beat.coeffs);
          prev_flush = mon_beat.flush;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] nf_exp;
    int cyc;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    b_we = 1'b0; b_addr = '0; b_wdata = '0; b_commit = 1'b0;
    mon_en = 1'b0; prev_flush = 1'b0;
    for (int i = 0; i < TAPS; i++) shadow_m[i] = INIT[i*CW +: CW];
    active_m = INIT;

    // T1: reset state.
    #12;
    step();
    rst = 1'b0;
    #1;
    check("t1_coeffs", fir_coeffs, INIT);
    check("t1_s_ready", s_ready, 1'b1);
    check("t1_busy", cfg_busy, 1'b0);
    check("t1_discard", out_discard, 1'b0);
    mon_en = 1'b1;
    step();

    // T2: zero-latency pass-through.
    s_valid = 1'b1; s_data = 16'd100;
    exp_q.push_back('{data: 16'd100, coeffs: active_m, flush: 1'b0});
    #1;
    check("t2_fir_valid", fir_valid, 1'b1);
    check("t2_fir_data", fir_data, 16'd100);
    step();
    s_valid = 1'b0;
    #1;
    check("t2_idle_valid", fir_valid, 1'b0);
    for (int i = 0; i < 4; i++) send(DW'($urandom_range(1, 16'hffff)));
    send(16'hffff);
    send(16'h0000);

    // T3: load all taps with 8, commit, check SWAP/FLUSH timing and resume on cycle 9.
    for (int i = 0; i < TAPS; i++) write_shadow(i, 16'd8);
    expect_swap_flush();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    check("t3_swap_ready", s_ready, 1'b0);
    check("t3_swap_valid", fir_valid, 1'b0);
    check("t3_swap_busy", cfg_busy, 1'b1);
    check("t3_swap_old_coeffs", fir_coeffs, INIT);
    s_valid = 1'b1; s_data = 16'd200;
    exp_q.push_back('{data: 16'd200, coeffs: active_m, flush: 1'b0});
    cyc = 1;
    while (!s_ready && cyc < 20) begin
      step();
      cyc++;
      if (cyc == 2) check("t3_new_coeffs", fir_coeffs, active_m);
    end
    check("t3_resume_cycle", cyc, 9);
    step();
    s_valid = 1'b0;
    step();

    // T4: a commit during FLUSH is held pending and produces a second swap right after.
    write_shadow(1, 16'd6);
    expect_swap_flush();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step(); step(); step();
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 16'd5; cfg_commit = 1'b1;
    shadow_m[3] = 16'd5;
    expect_swap_flush();
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    for (int c = 5; c <= 18; c++) begin
      check($sformatf("t4_busy_c%0d", c), cfg_busy, (c <= 17) ? 1'b1 : 1'b0);
      check($sformatf("t4_ready_c%0d", c), s_ready, (c == 9 || c == 18) ? 1'b1 : 1'b0);
      if (c < 18) step();
    end
    send(16'd321);

    // T5: a shadow write in the SWAP cycle does not reach the active bank until the next commit.
    expect_swap_flush();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'd9;
    step();
    cfg_we = 1'b0;
    shadow_m[0] = 16'd9;
    check("t5_tap0_old", fir_coeffs[CW-1:0], 16'd8);
    wait_ready("t5_flush1_done");
    send(16'd77);
    expect_swap_flush();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    wait_ready("t5_flush2_done");
    check("t5_tap0_new", fir_coeffs[CW-1:0], 16'd9);
    send(16'd78);

    // T6: asynchronous reset in the middle of FLUSH (flush_cnt = 3).
    write_shadow(2, 16'd11);
    expect_swap_flush();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step(); step(); step(); step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    prev_flush = 1'b0;
    #1;
    check("t6_ready", s_ready, 1'b1);
    check("t6_busy", cfg_busy, 1'b0);
    check("t6_discard", out_discard, 1'b0);
    check("t6_coeffs", fir_coeffs, INIT);
    exp_q.delete();
    for (int i = 0; i < TAPS; i++) shadow_m[i] = INIT[i*CW +: CW];
    active_m = INIT;
    step();
    rst = 1'b0;
    send(16'd55);
    // The shadow bank must also have reverted, so a commit now reloads INIT.
    expect_swap_flush();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    wait_ready("t6_flush_done");
    check("t6_coeffs_after_commit", fir_coeffs, INIT);
    send(16'd56);

    // FLUSH_EN = 0 instance: SWAP returns straight to RUN with no injected zeros.
    nf_exp = INIT;
    nf_exp[CW-1:0] = 16'd7;
    b_we = 1'b1; b_addr = 3'd0; b_wdata = 16'd7;
    step();
    b_we = 1'b0; b_commit = 1'b1;
    step();
    b_commit = 1'b0;
    check("nf_swap_ready", b_s_ready, 1'b0);
    check("nf_swap_busy", b_busy, 1'b1);
    check("nf_swap_coeffs", b_coeffs, INIT);
    step();
    check("nf_run_ready", b_s_ready, 1'b1);
    check("nf_run_busy", b_busy, 1'b0);
    check("nf_run_valid", b_fir_valid, 1'b0);
    check("nf_run_data", b_fir_data, '0);
    check("nf_run_coeffs", b_coeffs, nf_exp);
    step();
    check("nf_discard", b_discard, 1'b0);

    step(); step();
    mon_en = 1'b0;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
